// File: rtl/sudoku_pkg.sv
// Shared types, constants and the group-member mapping for the Sudoku sweep sequencer.
package sudoku_pkg;

  localparam int unsigned NCELLS  = 81;
  localparam int unsigned NGROUPS = 27;
  localparam int unsigned GSIZE   = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_APPLY,
    S_CHECK,
    S_LATCH,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    RES_SOLVED  = 2'd0,
    RES_STUCK   = 2'd1,
    RES_ILLEGAL = 2'd2,
    RES_TIMEOUT = 2'd3
  } result_t;

  // Cell index (row-major) of member k of group g.
  // Groups 0..8 are rows, 9..17 columns, 18..26 boxes.
  function automatic logic [6:0] group_member(input logic [4:0] g, input logic [3:0] k);
    int unsigned gi;
    int unsigned ki;
    int unsigned b;
    int unsigned idx;
    gi  = {27'd0, g};
    ki  = {28'd0, k};
    b   = 0;
    idx = 0;
    if (gi < 9) begin
      idx = 9 * gi + ki;
    end else if (gi < 18) begin
      idx = 9 * ki + (gi - 9);
    end else begin
      b   = gi - 18;
      idx = 27 * (b / 3) + 3 * (b % 3) + 9 * (ki / 3) + (ki % 3);
    end
    return 7'(idx);
  endfunction

endpackage

// File: rtl/sudoku_sweep_ctrl.sv
// Constraint-propagation sequencer: sweeps all 27 groups, filters candidates,
// latches singletons and repeats until solved, stuck, illegal or out of passes.
module sudoku_sweep_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned MAX_PASSES = 32,
  parameter int unsigned PASS_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic [PASS_W-1:0] passes,
  output logic [6:0]        cell_sel,
  output logic              cell_addr,
  output logic              cell_we,
  output logic [8:0]        cell_wdata,
  input  logic [8:0]        cell_rdata,
  output logic              latch_singleton,
  input  logic              any_singleton,
  input  logic              any_illegal,
  input  logic              all_solved
);

  localparam logic [PASS_W-1:0] MAX_P  = PASS_W'(MAX_PASSES);
  localparam logic [4:0]        LAST_G = 5'(NGROUPS - 1);
  localparam logic [3:0]        LAST_K = 4'(GSIZE - 1);

  state_t     state;
  logic [4:0] g;
  logic [3:0] k;
  logic [8:0] mask;
  logic       conflict;

  // Cell bus address/data decode from the registered sweep position.
  always_comb begin
    cell_sel   = '0;
    cell_addr  = 1'b0;
    cell_wdata = '0;
    if (state == S_GATHER || state == S_APPLY) begin
      cell_sel = group_member(g, k);
    end
    if (state == S_APPLY) begin
      cell_addr  = 1'b1;
      cell_wdata = ~mask;
    end
  end

  // Sweep FSM with registered status and strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      g               <= '0;
      k               <= '0;
      mask            <= '0;
      conflict        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= '0;
      passes          <= '0;
      cell_we         <= 1'b0;
      latch_singleton <= 1'b0;
    end else begin
      done            <= 1'b0;
      latch_singleton <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            passes   <= '0;
            g        <= '0;
            k        <= '0;
            mask     <= '0;
            conflict <= 1'b0;
            busy     <= 1'b1;
            state    <= S_GATHER;
          end
        end
        S_GATHER: begin
          if ((mask & cell_rdata) != '0) conflict <= 1'b1;
          mask <= mask | cell_rdata;
          if (k == LAST_K) begin
            k       <= '0;
            cell_we <= 1'b1;
            state   <= S_APPLY;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_APPLY: begin
          if (k == LAST_K) begin
            k       <= '0;
            mask    <= '0;
            cell_we <= 1'b0;
            if (g == LAST_G) begin
              state <= S_CHECK;
            end else begin
              g     <= g + 5'd1;
              state <= S_GATHER;
            end
          end else begin
            k <= k + 4'd1;
          end
        end
        S_CHECK: begin
          if (conflict || any_illegal) begin
            result <= RES_ILLEGAL;
            done   <= 1'b1;
            state  <= S_FINISH;
          end else if (all_solved) begin
            result <= RES_SOLVED;
            done   <= 1'b1;
            state  <= S_FINISH;
          end else if (!any_singleton) begin
            result <= RES_STUCK;
            done   <= 1'b1;
            state  <= S_FINISH;
          end else if (passes == MAX_P) begin
            result <= RES_TIMEOUT;
            done   <= 1'b1;
            state  <= S_FINISH;
          end else begin
            latch_singleton <= 1'b1;
            state           <= S_LATCH;
          end
        end
        S_LATCH: begin
          passes   <= passes + 1'b1;
          g        <= '0;
          conflict <= 1'b0;
          state    <= S_GATHER;
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_sweep_ctrl.sv
// Bench for sudoku_sweep_ctrl: behavioural cell array, a grid-level reference
// model producing the expected per-cycle trace, and directed puzzles.
module tb_sudoku_sweep_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       latch;
    logic       we;
    logic       addr;
    logic [6:0] sel;
    logic [8:0] wdata;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic use_t = 1'b0;
  logic load_req = 1'b0;
  always #5 clk = ~clk;

  // Two instances: default limits and a one-pass limit for the timeout case.
  logic       a_busy, a_done, a_addr, a_we, a_latch;
  logic [1:0] a_result;
  logic [5:0] a_passes;
  logic [6:0] a_sel;
  logic [8:0] a_wdata;
  logic       t_busy, t_done, t_addr, t_we, t_latch;
  logic [1:0] t_result;
  logic [5:0] t_passes;
  logic [6:0] t_sel;
  logic [8:0] t_wdata;
  logic [8:0] rdata;
  logic       any_s, any_i, all_s;

  sudoku_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start & ~use_t), .busy(a_busy), .done(a_done),
    .result(a_result), .passes(a_passes), .cell_sel(a_sel), .cell_addr(a_addr),
    .cell_we(a_we), .cell_wdata(a_wdata), .cell_rdata(rdata), .latch_singleton(a_latch),
    .any_singleton(any_s), .any_illegal(any_i), .all_solved(all_s)
  );

  sudoku_sweep_ctrl #(.MAX_PASSES(1), .PASS_W(6)) dut_t (
    .clk(clk), .reset(reset), .start(start & use_t), .busy(t_busy), .done(t_done),
    .result(t_result), .passes(t_passes), .cell_sel(t_sel), .cell_addr(t_addr),
    .cell_we(t_we), .cell_wdata(t_wdata), .cell_rdata(rdata), .latch_singleton(t_latch),
    .any_singleton(any_s), .any_illegal(any_i), .all_solved(all_s)
  );

  wire       o_busy   = use_t ? t_busy   : a_busy;
  wire       o_done   = use_t ? t_done   : a_done;
  wire       o_addr   = use_t ? t_addr   : a_addr;
  wire       o_we     = use_t ? t_we     : a_we;
  wire       o_latch  = use_t ? t_latch  : a_latch;
  wire [1:0] o_result = use_t ? t_result : a_result;
  wire [5:0] o_passes = use_t ? t_passes : a_passes;
  wire [6:0] o_sel    = use_t ? t_sel    : a_sel;
  wire [8:0] o_wdata  = use_t ? t_wdata  : a_wdata;

  // Behavioural cell array.
  logic [8:0] init_val[81];
  logic [8:0] val[81];
  logic [8:0] cand[81];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 81; i++) begin
        val[i]  <= init_val[i];
        cand[i] <= '1;
      end
    end else begin
      if (o_we && o_sel < 7'd81) cand[o_sel] <= cand[o_sel] & o_wdata;
      if (o_latch) begin
        for (int i = 0; i < 81; i++)
          if (val[i] == '0 && $countones(cand[i]) == 1) val[i] <= cand[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (o_sel < 7'd81) rdata = o_addr ? cand[o_sel] : val[o_sel];
  end

  always_comb begin
    any_s = 1'b0;
    any_i = 1'b0;
    all_s = 1'b1;
    for (int i = 0; i < 81; i++) begin
      if (val[i] == '0) begin
        all_s = 1'b0;
        if (cand[i] == '0) any_i = 1'b1;
        else if ($countones(cand[i]) == 1) any_s = 1'b1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic logic [8:0] onehot(input int v);
    logic [8:0] x;
    x = 9'd1;
    return x << (v - 1);
  endfunction

  function automatic int sol(input int r, input int c);
    return ((3 * r + r / 3 + c + 4) % 9) + 1;
  endfunction

  task automatic grid_empty();
    for (int i = 0; i < 81; i++) init_val[i] = '0;
  endtask

  task automatic grid_full();
    for (int i = 0; i < 81; i++) init_val[i] = onehot(sol(i / 9, i % 9));
  endtask

  // Reference model: whole-grid sweeps producing the expected output trace.
  rec_t exp_q[$];
  int   exp_result;
  int   exp_passes;

  task automatic build_model(input int maxp);
    logic [8:0] mv[81];
    logic [8:0] mc[81];
    int mem[9];
    int p;
    int n;
    bit fin;
    bit conf;
    bit solved;
    bit illegal;
    bit single;
    logic [8:0] m;
    exp_q.delete();
    for (int i = 0; i < 81; i++) begin
      mv[i] = init_val[i];
      mc[i] = '1;
    end
    p = 0;
    fin = 0;
    while (!fin) begin
      conf = 0;
      for (int g = 0; g < 27; g++) begin
        n = 0;
        for (int c = 0; c < 81; c++) begin
          if ((g < 9 && c / 9 == g) || (g >= 9 && g < 18 && c % 9 == g - 9) ||
              (g >= 18 && ((c / 27) * 3 + (c % 9) / 3) == g - 18)) begin
            mem[n] = c;
            n++;
          end
        end
        m = '0;
        for (int k = 0; k < 9; k++) begin
          if ((m & mv[mem[k]]) != '0) conf = 1;
          m = m | mv[mem[k]];
          exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'(mem[k]), 9'd0});
        end
        for (int k = 0; k < 9; k++) begin
          exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'(mem[k]), ~m});
          mc[mem[k]] = mc[mem[k]] & ~m;
        end
      end
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 9'd0});
      solved = 1; illegal = conf; single = 0;
      for (int i = 0; i < 81; i++) begin
        if (mv[i] == '0) begin
          solved = 0;
          if (mc[i] == '0) illegal = 1;
          else if ($countones(mc[i]) == 1) single = 1;
        end
      end
      fin = 1;
      if (illegal) exp_result = 2;
      else if (solved) exp_result = 0;
      else if (!single) exp_result = 1;
      else if (p == maxp) exp_result = 3;
      else begin
        fin = 0;
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 9'd0});
        for (int i = 0; i < 81; i++)
          if (mv[i] == '0 && $countones(mc[i]) == 1) mv[i] = mc[i];
        p++;
      end
    end
    exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 9'd0});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 9'd0});
    exp_passes = p;
  endtask

  task automatic load_grid();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  int run_len;
  int done_res;
  int done_passes;

  // One solve: start, then compare every cycle against the model trace.
  task automatic run(input bit tsel, input int maxp, input string name);
    rec_t act;
    int done_at;
    use_t = tsel;
    load_grid();
    build_model(maxp);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1;
    done_res = -1;
    done_passes = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 100) start = 1'b1;
      if (i == 101) start = 1'b0;
      act = '{o_busy, o_done, o_latch, o_we, o_addr, o_sel, o_wdata};
      total++;
      if (act !== exp_q[i]) begin
        bad++;
        $display("FAIL %s trace[%0d]: got %h want %h (busy,done,latch,we,addr,sel,wdata)",
                 name, i, act, exp_q[i]);
      end
      if (o_done && done_at < 0) begin
        done_at = i;
        done_res = int'(o_result);
        done_passes = int'(o_passes);
      end
      if (exp_q[i].done) begin
        chk({name, " result"}, 32'(o_result), 32'(exp_result));
        chk({name, " passes"}, 32'(o_passes), 32'(exp_passes));
      end
      @(negedge clk);
    end
    run_len = (done_at < 0) ? -1 : done_at + 2;
  endtask

  initial begin
    grid_empty();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle outputs", {a_busy, a_done, a_latch, a_we, a_addr, a_sel, a_wdata, a_result, a_passes},
          32'd0);
      @(negedge clk);
    end

    // One blank cell, answer 5.
    grid_full();
    init_val[0] = '0;
    run(1'b0, 32, "one_blank");
    chk("one_blank model passes", 32'(exp_passes), 32'd1);
    chk("one_blank result", 32'(done_res), 32'd0);
    chk("one_blank passes", 32'(done_passes), 32'd1);
    chk("one_blank len", 32'(run_len), 32'd977);
    chk("one_blank cell0", 32'(val[0]), 32'(9'b000010000));

    // Empty grid: stuck without any latch.
    grid_empty();
    run(1'b0, 32, "empty");
    chk("empty result", 32'(done_res), 32'd1);
    chk("empty passes", 32'(done_passes), 32'd0);
    chk("empty len", 32'(run_len), 32'd489);

    // Duplicate 7 in row 3.
    grid_empty();
    init_val[27] = onehot(7);
    init_val[32] = onehot(7);
    run(1'b0, 32, "illegal");
    chk("illegal result", 32'(done_res), 32'd2);
    chk("illegal passes", 32'(done_passes), 32'd0);
    chk("illegal len", 32'(run_len), 32'd489);

    // Chain puzzle: cells 7 and 13 resolve first, cell 4 one pass later.
    grid_full();
    init_val[4] = '0;
    init_val[7] = '0;
    init_val[13] = '0;
    run(1'b0, 32, "chain");
    chk("chain result", 32'(done_res), 32'd0);
    chk("chain passes", 32'(done_passes), 32'd2);
    chk("chain len", 32'(run_len), 32'd1465);
    chk("chain cell4", 32'(val[4]), 32'(9'b100000000));

    // Same chain with a one-pass limit.
    run(1'b1, 1, "timeout");
    chk("timeout result", 32'(done_res), 32'd3);
    chk("timeout passes", 32'(done_passes), 32'd1);
    chk("timeout len", 32'(run_len), 32'd977);
    use_t = 1'b0;

    // Reset in the middle of a run.
    grid_empty();
    load_grid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (198) @(negedge clk);
    chk("pre-reset busy", 32'(a_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset outputs", {a_busy, a_done, a_latch, a_we, a_addr, a_sel, a_wdata, a_result, a_passes},
        32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset quiet", {a_busy, a_we, a_latch}, 32'd0);
    end
    grid_full();
    init_val[0] = '0;
    run(1'b0, 32, "after_reset");
    chk("after_reset result", 32'(done_res), 32'd0);
    chk("after_reset passes", 32'(done_passes), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sudoku_sweep_ctrl.md
# sudoku_sweep_ctrl

Sequencer for the 81-cell Sudoku candidate array. It runs constraint-propagation passes: for each of the 27 groups (9 rows, 9 columns, 9 boxes) it reads the solved values, ORs them into a mask, and writes the complement back as a candidate filter. It then latches singletons array-wide and repeats until the grid is solved, stuck, illegal, or out of passes. It sits between the host register interface and the cell array, and owns the cell bus whenever `busy` is high.

## Interface

Parameters:
- `MAX_PASSES`, default 32: latch passes allowed before a timeout is declared.
- `PASS_W`, default 6: width of the pass counter; must satisfy 2^PASS_W > MAX_PASSES.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin solving; sampled only in IDLE.
- `busy` output 1: high from the cycle after `start` until `done`, inclusive.
- `done` output 1: one-cycle pulse at completion.
- `result` output 2: 0 = solved, 1 = stuck, 2 = illegal, 3 = timeout. Held from `done` until the next `start`.
- `passes` output PASS_W: number of latch pulses issued in the current or last run.
- `cell_sel` output 7: selected cell, 0..80, numbered row-major.
- `cell_addr` output 1: 0 = value plane, 1 = candidate plane.
- `cell_we` output 1: write strobe to the selected cell.
- `cell_wdata` output 9: write data, bits [9:1].
- `cell_rdata` input 9: read data from the selected cell; combinational, valid in the same cycle.
- `latch_singleton` output 1: broadcast to all 81 cells.
- `any_singleton` input 1: OR of `is_singleton` across all cells.
- `any_illegal` input 1: OR of `is_illegal` across all cells.
- `all_solved` input 1: AND of `solved` across all cells.

## Operation

States: IDLE, GATHER, APPLY, CHECK, LATCH, FINISH.

- **IDLE**
  - On `start`: clear `passes`, group index g = 0, member index k = 0, mask = 0, conflict = 0, then go to GATHER.
- **GATHER** (9 cycles per group)
  - Drive `cell_sel` = member(g,k), `cell_addr` = 0, `cell_we` = 0.
  - If (mask & `cell_rdata`) != 0, set conflict.
  - Update mask |= `cell_rdata`.
  - At k = 8, wrap k to 0 and go to APPLY.
- **APPLY** (9 cycles per group)
  - Drive `cell_sel` = member(g,k), `cell_addr` = 1, `cell_we` = 1, `cell_wdata` = ~mask.
  - At k = 8: clear mask and k. If g = 26, go to CHECK; otherwise increment g and return to GATHER.
- **CHECK** (priority order)
  1. conflict or `any_illegal` → result 2.
  2. `all_solved` → result 0.
  3. !`any_singleton` → result 1.
  4. `passes` == MAX_PASSES → result 3.
  5. Otherwise go to LATCH.
  - Cases 1–4 go to FINISH.
- **LATCH**
  - Pulse `latch_singleton` for exactly 1 cycle.
  - Increment `passes`, set g = 0, clear conflict, go to GATHER.
- **FINISH**
  - Pulse `done`, drop `busy` after this cycle, return to IDLE.

Group member mapping, for k = 0..8:
- Rows, g = 0..8: 9g + k.
- Columns, g = 9..17: 9k + (g − 9).
- Boxes, g = 18..26, with b = g − 18: 27(b/3) + 3(b%3) + 9(k/3) + (k%3).

Other rules:
- Outside GATHER/APPLY, `cell_we` = 0 and `cell_wdata` = 0.
- `start` during `busy` is ignored.

## Timing

- Each group takes 18 cycles; a full pass is 486 cycles, plus 1 CHECK cycle and 1 LATCH cycle.
- `start` → first GATHER read: 1 cycle.
- CHECK → `done`: 1 cycle.
- Total run length: 1 + (passes + 1)·487 + passes + 1 cycles.
- Reset values of outputs: `busy` 0, `done` 0, `result` 0, `passes` 0, `cell_sel` 0, `cell_addr` 0, `cell_we` 0, `cell_wdata` 0, `latch_singleton` 0.
- Reset mid-run forces IDLE within 1 cycle with no further writes. The cell array shares the same reset.
- All outputs are registered except `cell_sel`, `cell_addr` and `cell_wdata`, which decode from registered state.

## Structure

- Package `sudoku_pkg` holds:
  - state enum;
  - result codes SOLVED / STUCK / ILLEGAL / TIMEOUT;
  - constants NCELLS = 81, NGROUPS = 27, GSIZE = 9;
  - function `group_member(g,k)`.
- No sub-module; `group_member` is a combinational function.

## Test plan

- Reset, then idle 5 cycles → all outputs 0, `cell_we` never asserted.
- Grid with one blank cell (row 0, col 0; answer 5) → one LATCH; `done` with `result` = 0, `passes` = 1; cell 0 value reads 9'b000010000.
- Empty grid → CHECK sees no singleton; `done` after 489 cycles from `start` with `result` = 1, `passes` = 0.
- Two cells in row 3 preloaded with value 7 → conflict in group 3; `result` = 2 after the first pass.
- MAX_PASSES = 1 with a puzzle needing 3 passes → `result` = 3, `passes` = 1.
- Assert `reset` at cycle 200 of a run → `busy` 0 next cycle, no `cell_we`; a new `start` then completes normally.
